fir_mode_ctrl: RTL
==================

FIR_MODE_CTRL -- requirements
Module: fir_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 64: filter order; the coefficient count is NUM_TAPS+1.
REQ-002 SHALL have parameter FLUSH_SAMPLES, default 68: left samples of mute after a load (65 buffer, 3 pipeline).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 122880: MCLK cycles the switch value must be stable (10 ms at 12.288 MHz).
REQ-004 SHALL have port MCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port SWITCH, input, 4 bits: raw, asynchronous mode switches.
REQ-007 SHALL have port LEFT_RX_READY, input, 1 bit: one-cycle left-sample strobe; it is the sample-boundary reference.
REQ-008 SHALL have port COEF_BANK, output, 2 bits: coefficient bank being loaded or active.
REQ-009 SHALL have port COEF_IDX, output, 7 bits: coefficient index, 0..NUM_TAPS.
REQ-010 SHALL have port COEF_LOAD, output, 1 bit: write strobe for COEF_BANK/COEF_IDX.
REQ-011 SHALL have port FIR_EN, output, 1 bit: 1 selects the filtered path, 0 selects bypass.
REQ-012 SHALL have port MUTE, output, 1 bit: 1 forces the transmitted samples to zero.
REQ-013 SHALL have port BUSY, output, 1 bit: 1 in any state other than BYPASS or RUN.

Function
REQ-014 SHALL synchronise SWITCH through 2 flops before any use.
REQ-015 SHALL decode the target mode from the stable switch value: 0001 gives bank 0 (lowpass), 0010 gives bank 1 (highpass), 0100 gives bank 2 (bandpass), 1000 gives bank 3 (bandstop), and any other value gives bypass.
REQ-016 SHALL implement the states BYPASS, MUTE_IN, LOAD, FLUSH and RUN, held in registered outputs.
REQ-017 SHALL, in BYPASS or RUN, go to MUTE_IN when the stable target differs from the active mode, and assert MUTE on the next cycle.
REQ-018 SHALL stay in MUTE_IN until the next LEFT_RX_READY, then go to LOAD for a filter target or to BYPASS for a bypass target.
REQ-019 SHALL, in LOAD, assert COEF_LOAD for exactly NUM_TAPS+1 consecutive cycles with COEF_IDX = 0,1,...,NUM_TAPS and COEF_BANK constant, then go to FLUSH.
REQ-020 SHALL, in FLUSH, count LEFT_RX_READY strobes and go to RUN on the strobe that makes the count FLUSH_SAMPLES.
REQ-021 SHALL drive FIR_EN=1, MUTE=0 in RUN and FIR_EN=0, MUTE=0 in BYPASS; FIR_EN SHALL rise on entry to LOAD.
REQ-022 SHALL always complete a LOAD once started; a target change during LOAD is latched as pending and acted on when LOAD ends.
REQ-023 SHALL, when a target change occurs in FLUSH, abort the flush, clear its count and go to LOAD (filter target) or BYPASS (bypass target).
REQ-024 SHALL keep MUTE asserted continuously from MUTE_IN until RUN or BYPASS is reached, across back-to-back changes.
REQ-025 SHALL, when LEFT_RX_READY coincides with the MUTE_IN entry cycle, not use that strobe; MUTE_IN waits for the next one.

Reset
REQ-026 SHALL, while RESET_N=0, put the block in BYPASS with FIR_EN=0, MUTE=0, COEF_LOAD=0, COEF_IDX=0, COEF_BANK=0, BUSY=0, counters cleared and synchronisers cleared to 0000.
REQ-027 SHALL, when reset is asserted mid-LOAD or mid-FLUSH, reach the reset values immediately and not resume the sequence.
REQ-028 SHALL, after reset release, re-evaluate the stable switch value normally, so a held 0001 gives a full load sequence.

Configuration
REQ-029 SHALL, with FIR_CTRL_DEBOUNCE_EN defined, update the stable value only after the synchronised value has been unchanged for DEBOUNCE_CYCLES cycles; any change restarts the count.
REQ-030 SHALL, with FIR_CTRL_DEBOUNCE_EN undefined, use the synchronised value directly as the stable value and exclude the debounce counter.

Structure
REQ-031 SHALL take the state enum, the bank constants (LPF/HPF/BPF/BSF = 0..3) and the one-hot switch codes from the shared package fir_pkg.
REQ-032 SHALL place the synchroniser and debounce in one sub-module, switch_debounce; the FSM stays in fir_mode_ctrl.

Verification
REQ-033 SHALL include this scenario: reset, then SWITCH=0001 held -> after the debounce, MUTE=1, one strobe later 65 COEF_LOAD cycles with idx 0..64 and bank 0, 68 strobes later MUTE=0, FIR_EN=1.
REQ-034 SHALL include this scenario: in RUN bank 0, SWITCH=0000 -> MUTE for 1 sample, then FIR_EN=0, MUTE=0, and no COEF_LOAD.
REQ-035 SHALL include this scenario: SWITCH 0010 then 1000 at LOAD idx 30 -> bank 1 load finishes to idx 64, an immediate bank 3 load follows, and MUTE never drops.
REQ-036 SHALL include this scenario: change to 0100 at FLUSH count 40 -> LOAD of bank 2, and the flush restarts at count 0.
REQ-037 SHALL include this scenario: RESET_N low at LOAD idx 10 -> all outputs go to the reset values asynchronously.
REQ-038 SHALL include this scenario: with FIR_CTRL_DEBOUNCE_EN defined, a 0001 glitch shorter than DEBOUNCE_CYCLES -> no state change.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared states, bank codes and switch decode for the FIR mode controller
package fir_pkg;

    typedef enum logic [2:0] {
        BYPASS,
        MUTE_IN,
        LOAD,
        FLUSH,
        RUN
    } fir_state_t;

    localparam logic [1:0] BANK_LPF = 2'd0;
    localparam logic [1:0] BANK_HPF = 2'd1;
    localparam logic [1:0] BANK_BPF = 2'd2;
    localparam logic [1:0] BANK_BSF = 2'd3;

    localparam logic [3:0] SW_LPF = 4'b0001;
    localparam logic [3:0] SW_HPF = 4'b0010;
    localparam logic [3:0] SW_BPF = 4'b0100;
    localparam logic [3:0] SW_BSF = 4'b1000;

    typedef struct packed {
        logic       filt;
        logic [1:0] bank;
    } fir_mode_t;

    localparam fir_mode_t MODE_BYPASS = '{filt: 1'b0, bank: 2'd0};

    // Anything that is not exactly one-hot selects bypass.
    function automatic fir_mode_t decode_switch(input logic [3:0] sw);
        fir_mode_t m;
        m = MODE_BYPASS;
        case (sw)
            SW_LPF:  m = '{filt: 1'b1, bank: BANK_LPF};
            SW_HPF:  m = '{filt: 1'b1, bank: BANK_HPF};
            SW_BPF:  m = '{filt: 1'b1, bank: BANK_BPF};
            SW_BSF:  m = '{filt: 1'b1, bank: BANK_BSF};
            default: m = MODE_BYPASS;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fir_mode_ctrl_if.sv
// rtl/fir_mode_ctrl_if.sv - stable switch bus from the debounce block to the mode FSM
interface fir_mode_ctrl_if;
    logic [3:0] sw_stable;

    modport master (output sw_stable);
    modport slave  (input  sw_stable);
endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - 2-flop switch synchroniser; debounce filter under FIR_CTRL_DEBOUNCE_EN
module switch_debounce
`ifdef FIR_CTRL_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 122880
)
`endif
(
    input  logic            MCLK,
    input  logic            RESET_N,
    input  logic [3:0]      SWITCH,
    fir_mode_ctrl_if.master sw_bus
);

    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q1 <= 4'b0000;
            sync_q2 <= 4'b0000;
        end else begin
            sync_q1 <= SWITCH;
            sync_q2 <= sync_q1;
        end
    end

`ifdef FIR_CTRL_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       cand;
    logic [3:0]       stable;
    logic [CNT_W-1:0] cnt;

    // Counter saturates at CNT_LAST; any movement of the input restarts it.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cand   <= 4'b0000;
            stable <= 4'b0000;
            cnt    <= '0;
        end else if (sync_q2 != cand) begin
            cand <= sync_q2;
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= cand;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sw_bus.sw_stable = stable;
`else
    assign sw_bus.sw_stable = sync_q2;
`endif

endmodule

// File: rtl/fir_mode_ctrl.sv
// rtl/fir_mode_ctrl.sv - FIR mode FSM: mute, coefficient load, flush; debounce via FIR_CTRL_DEBOUNCE_EN
module fir_mode_ctrl
    import fir_pkg::*;
#(
    parameter int NUM_TAPS        = 64,
    parameter int FLUSH_SAMPLES   = 68,
    parameter int DEBOUNCE_CYCLES = 122880
) (
    input  logic       MCLK,
    input  logic       RESET_N,
    input  logic [3:0] SWITCH,
    input  logic       LEFT_RX_READY,
    output logic [1:0] COEF_BANK,
    output logic [6:0] COEF_IDX,
    output logic       COEF_LOAD,
    output logic       FIR_EN,
    output logic       MUTE,
    output logic       BUSY
);

    localparam logic [6:0]      LAST_IDX   = 7'(NUM_TAPS);
    localparam int              FL_W       = $clog2(FLUSH_SAMPLES + 1);
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_SAMPLES - 1);

    fir_mode_ctrl_if sw_bus ();

`ifdef FIR_CTRL_DEBOUNCE_EN
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .SWITCH  (SWITCH),
        .sw_bus  (sw_bus)
    );
`else
    switch_debounce u_debounce (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .SWITCH  (SWITCH),
        .sw_bus  (sw_bus)
    );
`endif

    fir_mode_t  target;
    fir_mode_t  active;
    fir_state_t state;
    logic       mute_armed;
    logic [FL_W-1:0] flush_cnt;

    assign target = decode_switch(sw_bus.sw_stable);

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= BYPASS;
            active     <= MODE_BYPASS;
            mute_armed <= 1'b0;
            flush_cnt  <= '0;
            COEF_BANK  <= 2'd0;
            COEF_IDX   <= 7'd0;
            COEF_LOAD  <= 1'b0;
            FIR_EN     <= 1'b0;
            MUTE       <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            case (state)
                BYPASS, RUN: begin
                    if (target != active) begin
                        state      <= MUTE_IN;
                        MUTE       <= 1'b1;
                        BUSY       <= 1'b1;
                        mute_armed <= 1'b0;
                    end
                end

                // The strobe in the first MUTE_IN cycle may belong to a sample
                // that left unmuted, so only later strobes count.
                MUTE_IN: begin
                    mute_armed <= 1'b1;
                    if (mute_armed && LEFT_RX_READY) begin
                        if (target.filt) begin
                            state     <= LOAD;
                            active    <= target;
                            COEF_BANK <= target.bank;
                            COEF_IDX  <= 7'd0;
                            COEF_LOAD <= 1'b1;
                            FIR_EN    <= 1'b1;
                        end else begin
                            state  <= BYPASS;
                            active <= MODE_BYPASS;
                            FIR_EN <= 1'b0;
                            MUTE   <= 1'b0;
                            BUSY   <= 1'b0;
                        end
                    end
                end

                LOAD: begin
                    if (COEF_IDX == LAST_IDX) begin
                        if (target == active) begin
                            state     <= FLUSH;
                            COEF_LOAD <= 1'b0;
                            flush_cnt <= '0;
                        end else if (target.filt) begin
                            active    <= target;
                            COEF_BANK <= target.bank;
                            COEF_IDX  <= 7'd0;
                        end else begin
                            state     <= BYPASS;
                            active    <= MODE_BYPASS;
                            COEF_LOAD <= 1'b0;
                            FIR_EN    <= 1'b0;
                            MUTE      <= 1'b0;
                            BUSY      <= 1'b0;
                        end
                    end else begin
                        COEF_IDX <= COEF_IDX + 7'd1;
                    end
                end

                FLUSH: begin
                    if (target != active) begin
                        flush_cnt <= '0;
                        if (target.filt) begin
                            state     <= LOAD;
                            active    <= target;
                            COEF_BANK <= target.bank;
                            COEF_IDX  <= 7'd0;
                            COEF_LOAD <= 1'b1;
                        end else begin
                            state  <= BYPASS;
                            active <= MODE_BYPASS;
                            FIR_EN <= 1'b0;
                            MUTE   <= 1'b0;
                            BUSY   <= 1'b0;
                        end
                    end else if (LEFT_RX_READY) begin
                        if (flush_cnt == FLUSH_LAST) begin
                            state     <= RUN;
                            flush_cnt <= '0;
                            MUTE      <= 1'b0;
                            BUSY      <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + FL_W'(1);
                        end
                    end
                end

                default: state <= BYPASS;
            endcase
        end
    end

endmodule
